// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan-control bus between the sequencer, the mux and the frame consumer
interface mux_scan_ctrl_if #(
  parameter int NUM_CH = 32,
  parameter int SEL_W = 5,
  parameter int DATA_W = 2
);
  logic start;
  logic [SEL_W-1:0] sel_out;
  logic [DATA_W-1:0] mux_out;
  logic [NUM_CH*DATA_W-1:0] frame;
  logic frame_valid;
  logic frame_ready;
  logic busy;
  modport master (
    input start, mux_out, frame_ready,
    output sel_out, frame, frame_valid, busy
  );
  modport slave (
    output start, mux_out, frame_ready,
    input sel_out, frame, frame_valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the mux select through every channel and packs the samples into one frame
module mux_scan_ctrl #(
  parameter int NUM_CH = 32,
  parameter int SEL_W = 5,
  parameter int DATA_W = 2
) (
  input logic clk,
  input logic reset,
  mux_scan_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, SCAN, VALID} state_t;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  state_t state, state_nxt;
  logic [SEL_W-1:0] ch_cnt, cnt_nxt;
  logic [NUM_CH-1:0][DATA_W-1:0] frame_q;
  logic valid_q, busy_q;
  logic last;
  always_comb begin
    last = ch_cnt == LAST;
    state_nxt = state == IDLE  ? (bus.start ? SCAN : IDLE) :
                state == SCAN  ? (last ? VALID : SCAN) :
                state == VALID ? (bus.frame_ready ? (bus.start ? SCAN : IDLE) : VALID) :
                IDLE;
    cnt_nxt = state == SCAN && !last ? ch_cnt + 1'b1 : '0;
  end
  // ch_cnt rests at 0 outside SCAN, so it doubles as the registered select
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch_cnt <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ch_cnt <= cnt_nxt;
      valid_q <= state_nxt == VALID;
      busy_q <= state_nxt == SCAN;
      if (state == SCAN) frame_q[ch_cnt] <= bus.mux_out;
    end
  end
  assign bus.sel_out = ch_cnt;
  assign bus.frame = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench; expected frames are queued by the driver and checked at each handshake
module tb_mux_scan_ctrl;
  localparam int NUM_CH = 32;
  localparam int FW = 64;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] inp [NUM_CH];
  logic [1:0] nxt_inp [NUM_CH];
  logic [FW-1:0] q [$];
  int total = 0;
  int passed = 0;
  mux_scan_ctrl_if bus ();
  mux_scan_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.mux_out = inp[bus.sel_out];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (!reset && bus.frame_valid && bus.frame_ready) begin
      if (q.size() == 0) chk("frame_unexpected", 1, 0);
      else chk("frame", bus.frame, q.pop_front());
    end
  end
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.frame_ready = v;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = !bus.frame_valid && !bus.busy;
    end
    chk("idle_reached", FW'(ok), 1);
  endtask
  task automatic scan(input int chg_at, input int poke_at, output logic [FW-1:0] e);
    bit seq_ok = 1;
    e = '0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      @(negedge clk);
      if (bus.sel_out != i || !bus.busy || bus.frame_valid) seq_ok = 0;
      if (i == chg_at) inp = nxt_inp;
      e[i*2 +: 2] = inp[i];
      bus.start = i == poke_at;
      if (i == NUM_CH - 1) q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("sel_sequence", FW'(seq_ok), 1);
    chk("valid_latency", {bus.frame_valid, bus.busy}, 2'b10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [FW-1:0] e;
    bit ok;
    int gap;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.frame_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) inp[c] = 2'(c);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_sel", bus.sel_out, 0);
    chk("reset_frame", bus.frame, 0);
    chk("reset_valid", bus.frame_valid, 0);
    chk("reset_busy", bus.busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.frame_ready = 1'b1;
    scan(99, 99, e);
    chk("basic_frame", bus.frame, 64'hE4E4E4E4E4E4E4E4);
    wait_idle();
    set_ready(1'b0);
    for (int c = 0; c < NUM_CH; c++) inp[c] = 2'($urandom);
    scan(99, 99, e);
    ok = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      bus.start = n == 5;
      if (!bus.frame_valid || bus.busy || bus.frame !== e) ok = 0;
    end
    bus.start = 1'b0;
    chk("backpressure_hold", FW'(ok), 1);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("after_handshake", {bus.frame_valid, bus.busy, bus.sel_out}, 0);
    for (int c = 0; c < NUM_CH; c++) inp[c] = 2'b11;
    q.push_back('1);
    q.push_back('1);
    @(negedge clk);
    bus.start = 1'b1;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.frame_valid;
    end
    chk("b2b_first_valid", FW'(ok), 1);
    chk("b2b_first_frame", bus.frame, '1);
    gap = 0;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = bus.frame_valid;
      if (!ok) gap++;
    end
    bus.start = 1'b0;
    chk("b2b_gap", FW'(gap), 32);
    chk("b2b_second_frame", bus.frame, '1);
    wait_idle();
    for (int c = 0; c < NUM_CH; c++) begin
      inp[c] = 2'b00;
      nxt_inp[c] = c < 20 ? 2'b00 : 2'b01;
    end
    scan(20, 99, e);
    chk("midscan_change", bus.frame, 64'h5555550000000000);
    wait_idle();
    for (int c = 0; c < NUM_CH; c++) inp[c] = 2'($urandom);
    scan(99, 5, e);
    wait_idle();
    ok = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.busy || bus.frame_valid) ok = 0;
    end
    chk("no_extra_scan", FW'(ok), 1);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i <= 10; i++) @(negedge clk);
    chk("midscan_sel10", bus.sel_out, 10);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_sel", bus.sel_out, 0);
    chk("midreset_frame", bus.frame, 0);
    chk("midreset_valid", bus.frame_valid, 0);
    chk("midreset_busy", bus.busy, 0);
    for (int c = 0; c < NUM_CH; c++) inp[c] = 2'($urandom);
    scan(99, 99, e);
    wait_idle();
    for (int r = 0; r < 8; r++) begin
      int hold;
      for (int c = 0; c < NUM_CH; c++) begin
        inp[c] = 2'($urandom);
        nxt_inp[c] = 2'($urandom);
      end
      hold = $urandom_range(0, 4);
      if (hold > 0) set_ready(1'b0);
      scan($urandom_range(0, 40), $urandom_range(0, 40), e);
      if (hold > 0) begin
        repeat (hold) @(posedge clk);
        #1 bus.frame_ready = 1'b1;
      end
      wait_idle();
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", FW'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
